// File: rtl/reg_file.sv
// Small multi-port register file: one synchronous write port, two combinational
// read ports, all entries cleared by an asynchronous active-low reset.
module reg_file #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset wins over a coincident write; the pending write is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // No write bypass: reads see the stored value, new data appears after the edge.
    assign rd0_data = mem[rd0_addr];
    assign rd1_data = mem[rd1_addr];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, entry 0,
// write disable, read-during-write, shared address and asynchronous reset.
module tb_reg_file;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic              rst;
    logic              clk;
    logic              wr_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd0_data;
    logic [DATA_W-1:0] rd1_data;

    int errors = 0;
    int checks = 0;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .rst      (rst),
        .clk      (clk),
        .wr_en    (wr_en),
        .rd0_addr (rd0_addr),
        .rd1_addr (rd1_addr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd0_data (rd0_data),
        .rd1_data (rd1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write one entry: drive on the falling edge, let the rising edge capture it.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 2'd3;
        wr_data  = 9'h1FF;
        rd0_addr = '0;
        rd1_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd0_addr = ADDR_W'(i);
            rd1_addr = ADDR_W'(i);
            #1;
            checks++;
            if (rd0_data !== 9'd0) begin
                errors++;
                $display("FAIL reset_rd0 addr=%0d got=%0d exp=0", i, rd0_data);
            end
            checks++;
            if (rd1_data !== 9'd0) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%0d exp=0", i, rd1_data);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b1;
        rd0_addr = 2'd3;
        @(posedge clk);
        #1;
        checks++;
        if (rd0_data !== 9'd0) begin
            errors++;
            $display("FAIL reset_entry3_after_release got=%0d exp=0", rd0_data);
        end
    endtask

    task automatic test_basic();
        do_write(2'd2, 9'd92);
        do_write(2'd1, 9'd65);
        rd0_addr = 2'd1;
        rd1_addr = 2'd2;
        #1;
        checks++;
        if (rd0_data !== 9'd65) begin
            errors++;
            $display("FAIL basic_rd0 got=%0d exp=65", rd0_data);
        end
        checks++;
        if (rd1_data !== 9'd92) begin
            errors++;
            $display("FAIL basic_rd1 got=%0d exp=92", rd1_data);
        end
    endtask

    task automatic test_entry0();
        logic [DATA_W-1:0] exp_v [DEPTH];
        exp_v[0] = 9'd12;
        exp_v[1] = 9'd65;
        exp_v[2] = 9'd92;
        exp_v[3] = 9'd0;
        do_write(2'd0, 9'd12);
        for (int i = 0; i < 3; i++) begin
            rd0_addr = ADDR_W'(i);
            #1;
            checks++;
            if (rd0_data !== exp_v[i]) begin
                errors++;
                $display("FAIL entry0_contents addr=%0d got=%0d exp=%0d", i, rd0_data, exp_v[i]);
            end
        end
    endtask

    task automatic test_write_disable_rdw();
        logic [DATA_W-1:0] exp_v [DEPTH];
        exp_v[0] = 9'd12;
        exp_v[1] = 9'd65;
        exp_v[2] = 9'd92;
        exp_v[3] = 9'd0;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 2'd2;
        wr_data = 9'd300;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd1_addr = ADDR_W'(i);
            #1;
            checks++;
            if (rd1_data !== exp_v[i]) begin
                errors++;
                $display("FAIL wr_disabled addr=%0d got=%0d exp=%0d", i, rd1_data, exp_v[i]);
            end
        end
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = 2'd2;
        wr_data  = 9'd300;
        rd1_addr = 2'd2;
        #1;
        checks++;
        if (rd1_data !== 9'd92) begin
            errors++;
            $display("FAIL rdw_before_edge got=%0d exp=92", rd1_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd1_data !== 9'd300) begin
            errors++;
            $display("FAIL rdw_after_edge got=%0d exp=300", rd1_data);
        end
        // Holding the write for more cycles must leave the value stable.
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd1_data !== 9'd300) begin
            errors++;
            $display("FAIL rdw_held got=%0d exp=300", rd1_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_same_addr();
        do_write(2'd3, 9'h1FF);
        rd0_addr = 2'd3;
        rd1_addr = 2'd3;
        #1;
        checks++;
        if (rd0_data !== 9'd511) begin
            errors++;
            $display("FAIL same_addr_rd0 got=%0d exp=511", rd0_data);
        end
        checks++;
        if (rd1_data !== 9'd511) begin
            errors++;
            $display("FAIL same_addr_rd1 got=%0d exp=511", rd1_data);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rd0_addr = 2'd3;
        rd1_addr = 2'd2;
        wr_en    = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 9'd77;
        #1;
        checks++;
        if (rd0_data !== 9'd511 || rd1_data !== 9'd300) begin
            errors++;
            $display("FAIL async_pre rd0=%0d rd1=%0d exp 511/300", rd0_data, rd1_data);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rd0_data !== 9'd0) begin
            errors++;
            $display("FAIL async_rd0 got=%0d exp=0", rd0_data);
        end
        checks++;
        if (rd1_data !== 9'd0) begin
            errors++;
            $display("FAIL async_rd1 got=%0d exp=0", rd1_data);
        end
        // Write pending at the next edge while reset is low must be lost.
        @(posedge clk);
        #1;
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd0_addr = ADDR_W'(i);
            #1;
            checks++;
            if (rd0_data !== 9'd0) begin
                errors++;
                $display("FAIL async_cleared addr=%0d got=%0d exp=0", i, rd0_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_entry0();
        test_write_disable_rdw();
        test_same_addr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Small multi-port register file: 4 entries of 9 bits, two independent read ports and one write port.
- Used as operand/scratch storage in the encryption/decryption datapath.
- Reads are combinational; the write is synchronous to the clock; contents clear on reset.

Parameters:
- DATA_W, 9, width of each entry and of the data ports.
- ADDR_W, 2, address width; depth = 2**ADDR_W (default 4 entries).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears every entry.
- wr_en  input  1  write enable, sampled on the rising edge of clk.
- rd0_addr  input  ADDR_W  read port 0 address.
- rd1_addr  input  ADDR_W  read port 1 address.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd0_data  output  DATA_W  contents of entry rd0_addr.
- rd1_data  output  DATA_W  contents of entry rd1_addr.
- Positional port order is exactly: rst, clk, wr_en, rd0_addr, rd1_addr, wr_addr, wr_data, rd0_data, rd1_data.

Behaviour:
- Storage: 2**ADDR_W registers, each DATA_W bits. Entry 0 is an ordinary writable register, not hardwired.
- Reset:
  - rst low immediately (asynchronously, no clock needed) forces every entry to 0.
  - Both read outputs therefore read 0 while reset is held.
  - While rst is low, writes are ignored.
  - Deassertion is sampled normally; the first write takes effect on the first rising edge with rst high and wr_en high.
- Write:
  - On the rising edge of clk with rst high and wr_en high, entry[wr_addr] <= wr_data.
  - wr_en low leaves all entries unchanged.
  - Holding wr_en high for many cycles rewrites the same value each cycle with no side effects.
- Read:
  - rd0_data = entry[rd0_addr] and rd1_data = entry[rd1_addr], purely combinational, zero-cycle latency from an address change.
  - Both ports may address the same entry simultaneously; both return the same value.
- Read-during-write to the same address:
  - No bypass. The read port shows the old value until the clock edge, then the new value in the same cycle the storage updates.
- Widths: wr_data stored unmodified; no sign extension, no truncation (port widths equal DATA_W). Addresses always in range because depth = 2**ADDR_W.
- Reset mid-operation: asserting rst at any time, including in the same cycle as an active write, wins; all entries read 0 and the pending write is lost.
- No X propagation: after reset every output is a defined value.

Test Plan:
- Reset: hold rst low, apply a clock and wr_en=1, wr_addr=3, wr_data=9'h1FF -> rd0_data=rd1_data=0 for all addresses; entry 3 still 0 after rst goes high.
- Basic write/read: rst high, write 92 to addr 2, then 65 to addr 1, wr_en=0; set rd0_addr=1, rd1_addr=2 -> rd0_data=65, rd1_data=92 combinationally, with no extra cycle.
- Entry 0 writable: wr_en=1, wr_addr=0, wr_data=12; rd0_addr=0 -> rd0_data=12 after the edge; entries 1 and 2 still 65 and 92.
- Write disabled / read-during-write: with wr_en=0, change wr_data to 300 -> no entry changes. Then with wr_en=1, wr_addr=2, wr_data=300 and rd1_addr=2 -> rd1_data=92 before the edge, 300 after it.
- Same address on both ports and full width: write 9'h1FF to addr 3, rd0_addr=rd1_addr=3 -> both outputs 511.
- Async reset mid-run: pull rst low between clock edges -> all outputs drop to 0 immediately, before the next edge.
